// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises IF word fetches and MEM byte/half/word loads and
// stores onto a byte-wide synchronous RAM port. MEM requests win over IF,
// and a store wins over a load. Each finished transaction is reported with
// a one-cycle done pulse on the port that issued it.
module mem_ctrl #(
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      if_re_i,
    input  logic [31:0]               if_addr_i,
    output logic [31:0]               if_data_o,
    output logic                      if_busy_o,
    output logic                      if_done_o,
    input  logic                      mem_re_i,
    input  logic                      mem_we_i,
    input  logic [31:0]               mem_addr_i,
    input  logic [1:0]                mem_width_i,
    input  logic [31:0]               mem_data_i,
    output logic [31:0]               mem_data_o,
    output logic                      mem_busy_o,
    output logic                      mem_done_o,
    output logic [RAM_ADDR_WIDTH-1:0] ram_a_o,
    output logic [7:0]                ram_dout_o,
    output logic                      ram_wr_o,
    input  logic [7:0]                ram_din_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                    state_q,    state_d;
    logic                      src_mem_q,  src_mem_d;   // read source: 1 = MEM, 0 = IF
    logic [RAM_ADDR_WIDTH-1:0] base_q,     base_d;      // latched request address
    logic [RAM_ADDR_WIDTH-1:0] ram_a_q,    ram_a_d;
    logic [2:0]                len_q,      len_d;       // byte count N (1, 2 or 4)
    logic [2:0]                cnt_q,      cnt_d;       // cycles spent in READ/WRITE
    logic [23:0]               wdata_q,    wdata_d;     // store bytes not yet driven
    logic [31:0]               rbuf_q,     rbuf_d;      // read bytes gathered so far
    logic [31:0]               if_data_q,  if_data_d;
    logic [31:0]               mem_data_q, mem_data_d;
    logic [7:0]                dout_q,     dout_d;
    logic                      wr_q,       wr_d;
    logic                      if_done_q,  if_done_d;
    logic                      mem_done_q, mem_done_d;
    logic [2:0]                nxt;

    // Address bits above the RAM width are dropped on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_i[31:RAM_ADDR_WIDTH], mem_addr_i[31:RAM_ADDR_WIDTH]};

    function automatic logic [2:0] width_to_len(input logic [1:0] w);
        case (w)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Next-state logic; everything holds while rdy is low.
    always_comb begin
        state_d    = state_q;
        src_mem_d  = src_mem_q;
        base_d     = base_q;
        ram_a_d    = ram_a_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        if_data_d  = if_data_q;
        mem_data_d = mem_data_q;
        dout_d     = dout_q;
        wr_d       = wr_q;
        if_done_d  = if_done_q;
        mem_done_d = mem_done_q;
        nxt        = cnt_q + 3'd1;

        if (rdy) begin
            if_done_d  = 1'b0;
            mem_done_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mem_we_i) begin
                        state_d = S_WRITE;
                        len_d   = width_to_len(mem_width_i);
                        cnt_d   = 3'd0;
                        base_d  = mem_addr_i[RAM_ADDR_WIDTH-1:0];
                        ram_a_d = mem_addr_i[RAM_ADDR_WIDTH-1:0];
                        dout_d  = mem_data_i[7:0];
                        wdata_d = mem_data_i[31:8];
                        wr_d    = 1'b1;
                    end else if (mem_re_i) begin
                        state_d   = S_READ;
                        src_mem_d = 1'b1;
                        len_d     = width_to_len(mem_width_i);
                        cnt_d     = 3'd0;
                        base_d    = mem_addr_i[RAM_ADDR_WIDTH-1:0];
                        ram_a_d   = mem_addr_i[RAM_ADDR_WIDTH-1:0];
                        rbuf_d    = 32'd0;
                    end else if (if_re_i) begin
                        state_d   = S_READ;
                        src_mem_d = 1'b0;
                        len_d     = 3'd4;
                        cnt_d     = 3'd0;
                        base_d    = if_addr_i[RAM_ADDR_WIDTH-1:0];
                        ram_a_d   = if_addr_i[RAM_ADDR_WIDTH-1:0];
                        rbuf_d    = 32'd0;
                    end
                end
                S_READ: begin
                    // RAM data lags the address by one edge, so lane k
                    // arrives when cnt_q == k+1.
                    cnt_d = nxt;
                    for (int i = 0; i < 4; i++) begin
                        if (cnt_q == 3'(i + 1)) begin
                            rbuf_d[8*i +: 8] = ram_din_i;
                        end
                    end
                    if (nxt < len_q) begin
                        ram_a_d = base_q + RAM_ADDR_WIDTH'(nxt);
                    end
                    if (cnt_q == len_q) begin
                        state_d = S_IDLE;
                        if (src_mem_q) begin
                            mem_data_d = rbuf_d;
                            mem_done_d = 1'b1;
                        end else begin
                            if_data_d = rbuf_d;
                            if_done_d = 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (nxt == len_q) begin
                        state_d    = S_IDLE;
                        wr_d       = 1'b0;
                        mem_done_d = 1'b1;
                    end else begin
                        cnt_d   = nxt;
                        ram_a_d = base_q + RAM_ADDR_WIDTH'(nxt);
                        dout_d  = wdata_q[7:0];
                        wdata_d = {8'h00, wdata_q[23:8]};
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    wr_d    = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset aborts any transaction at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            src_mem_q  <= 1'b0;
            base_q     <= '0;
            ram_a_q    <= '0;
            len_q      <= 3'd0;
            cnt_q      <= 3'd0;
            wdata_q    <= 24'd0;
            rbuf_q     <= 32'd0;
            if_data_q  <= 32'd0;
            mem_data_q <= 32'd0;
            dout_q     <= 8'd0;
            wr_q       <= 1'b0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_mem_q  <= src_mem_d;
            base_q     <= base_d;
            ram_a_q    <= ram_a_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            if_data_q  <= if_data_d;
            mem_data_q <= mem_data_d;
            dout_q     <= dout_d;
            wr_q       <= wr_d;
            if_done_q  <= if_done_d;
            mem_done_q <= mem_done_d;
        end
    end

    // IF also sees busy when a MEM request is about to win arbitration.
    assign if_busy_o  = (state_q != S_IDLE) | mem_re_i | mem_we_i;
    assign mem_busy_o = (state_q != S_IDLE);
    assign if_data_o  = if_data_q;
    assign if_done_o  = if_done_q;
    assign mem_data_o = mem_data_q;
    assign mem_done_o = mem_done_q;
    assign ram_a_o    = ram_a_q;
    assign ram_dout_o = dout_q;
    assign ram_wr_o   = wr_q & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: a byte RAM with one-cycle read latency, a vector
// table of directed transactions, hand-written corner sequences, and a
// randomized phase checked against a transaction-level memory model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_re_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_busy_o;
    logic        if_done_o;
    logic        mem_re_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [1:0]  mem_width_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_busy_o;
    logic        mem_done_o;
    logic [16:0] ram_a_o;
    logic [7:0]  ram_dout_o;
    logic        ram_wr_o;
    logic [7:0]  ram_din_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] last_if;
    logic [31:0] last_mem;

    // Byte RAM seen by the DUT, plus a separate expectation model.
    logic [7:0]  ram       [0:131071];
    logic [7:0]  model_ram [0:131071];
    logic        poke_en = 1'b0;
    logic [16:0] poke_a  = 17'd0;
    logic [7:0]  poke_d  = 8'd0;

    mem_ctrl #(.RAM_ADDR_WIDTH(17)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_re_i(if_re_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
        .if_busy_o(if_busy_o), .if_done_o(if_done_o),
        .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_width_i(mem_width_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
        .mem_busy_o(mem_busy_o), .mem_done_o(mem_done_o),
        .ram_a_o(ram_a_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o),
        .ram_din_i(ram_din_i)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: write when enabled, read data one edge late.
    always @(posedge clk) begin
        if (poke_en) ram[poke_a] <= poke_d;
        else if (ram_wr_o) ram[ram_a_o] <= ram_dout_o;
        ram_din_i <= ram[ram_a_o];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int width_len(input logic [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [16:0] a, input int n);
        logic [31:0] r;
        r = 32'd0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = model_ram[a + 17'(k)];
        return r;
    endfunction

    task automatic poke(input logic [16:0] a, input logic [7:0] d);
        poke_a = a;
        poke_d = d;
        poke_en = 1'b1;
        model_ram[a] = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // One transaction from an idle DUT, called at a falling edge.
    // op: 0 = IF read, 1 = MEM load, 2 = MEM store.
    task automatic run_txn(input string name, input int op, input logic [1:0] w,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp);
        int          n;
        int          lat;
        logic [16:0] a17;
        n   = (op == 0) ? 4 : width_len(w);
        lat = (op == 2) ? n : n + 1;
        a17 = addr[16:0];
        $display("txn %s op=%0d width=%0d addr=%h wdata=%h", name, op, w, addr, wdata);
        case (op)
            0: begin if_addr_i = addr; if_re_i = 1'b1; end
            1: begin mem_addr_i = addr; mem_width_i = w; mem_re_i = 1'b1; end
            default: begin
                mem_addr_i = addr; mem_width_i = w; mem_data_i = wdata; mem_we_i = 1'b1;
            end
        endcase
        #1;
        check({name, ".if_busy"}, 32'(if_busy_o), 32'(op != 0));
        check({name, ".mem_busy"}, 32'(mem_busy_o), 32'd0);
        @(negedge clk);
        // Request fields must already be latched; scramble the inputs.
        if_re_i = 1'b0; mem_re_i = 1'b0; mem_we_i = 1'b0;
        if_addr_i = $urandom; mem_addr_i = $urandom;
        mem_width_i = 2'($urandom_range(0, 3)); mem_data_i = $urandom;
        for (int i = 0; i <= lat; i++) begin
            if (i > 0) @(negedge clk);
            if (op == 0) begin
                check({name, ".if_done"}, 32'(if_done_o), 32'(i == lat));
                check({name, ".mem_done"}, 32'(mem_done_o), 32'd0);
            end else begin
                check({name, ".mem_done"}, 32'(mem_done_o), 32'(i == lat));
                check({name, ".if_done"}, 32'(if_done_o), 32'd0);
            end
            if (i < n) check({name, ".ram_a"}, 32'(ram_a_o), 32'(a17 + 17'(i)));
            check({name, ".ram_wr"}, 32'(ram_wr_o), 32'((op == 2) && (i < n)));
            if ((op == 2) && (i < n)) check({name, ".ram_dout"}, 32'(ram_dout_o), 32'(wdata[8*i +: 8]));
        end
        if (op == 0) begin
            check({name, ".if_data"}, if_data_o, exp);
            last_if = exp;
            check({name, ".mem_data_hold"}, mem_data_o, last_mem);
        end else if (op == 1) begin
            check({name, ".mem_data"}, mem_data_o, exp);
            last_mem = exp;
            check({name, ".if_data_hold"}, if_data_o, last_if);
        end else begin
            check({name, ".mem_data_hold"}, mem_data_o, last_mem);
            check({name, ".if_data_hold"}, if_data_o, last_if);
        end
    endtask

    typedef struct packed {
        logic [1:0]  op;
        logic [1:0]  w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int          s_wr [8];
        logic [16:0] s_a  [8];
        logic [7:0]  s_d  [8];

        vecs[0]  = '{2'd0, 2'd0, 32'h0000_0100, 32'h0,         32'h0010_0513};
        vecs[1]  = '{2'd0, 2'd0, 32'hFFFE_0100, 32'h0,         32'h0010_0513};
        vecs[2]  = '{2'd2, 2'd0, 32'h0000_0204, 32'h1234_56AB, 32'h0};
        vecs[3]  = '{2'd1, 2'd0, 32'h0000_0204, 32'h0,         32'h0000_00AB};
        vecs[4]  = '{2'd1, 2'd1, 32'h0000_0010, 32'h0,         32'h0000_ABCD};
        vecs[5]  = '{2'd2, 2'd2, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0};
        vecs[6]  = '{2'd1, 2'd2, 32'h0000_0300, 32'h0,         32'hDEAD_BEEF};
        vecs[7]  = '{2'd1, 2'd1, 32'h0000_0301, 32'h0,         32'h0000_ADBE};
        vecs[8]  = '{2'd1, 2'd3, 32'h0000_0302, 32'h0,         32'h2211_DEAD};
        vecs[9]  = '{2'd2, 2'd1, 32'h0000_0400, 32'hFFFF_5A5A, 32'h0};
        vecs[10] = '{2'd1, 2'd0, 32'h0000_0401, 32'h0,         32'h0000_005A};
        vecs[11] = '{2'd2, 2'd3, 32'h0000_0404, 32'h8765_4321, 32'h0};
        vecs[12] = '{2'd1, 2'd2, 32'h0000_0404, 32'h0,         32'h8765_4321};
        vecs[13] = '{2'd1, 2'd0, 32'h0000_0406, 32'h0,         32'h0000_0065};

        rst = 1'b0; rdy = 1'b1;
        if_re_i = 1'b0; if_addr_i = 32'd0;
        mem_re_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'd0;
        mem_width_i = 2'd0; mem_data_i = 32'd0;
        last_if = 32'd0; last_mem = 32'd0;

        // Reset values.
        @(negedge clk);
        check("rst.ram_a", 32'(ram_a_o), 32'd0);
        check("rst.ram_dout", 32'(ram_dout_o), 32'd0);
        check("rst.ram_wr", 32'(ram_wr_o), 32'd0);
        check("rst.if_data", if_data_o, 32'd0);
        check("rst.mem_data", mem_data_o, 32'd0);
        check("rst.if_done", 32'(if_done_o), 32'd0);
        check("rst.mem_done", 32'(mem_done_o), 32'd0);
        check("rst.if_busy", 32'(if_busy_o), 32'd0);
        check("rst.mem_busy", 32'(mem_busy_o), 32'd0);
        mem_re_i = 1'b1;
        #1;
        check("rst.if_busy_memreq", 32'(if_busy_o), 32'd1);
        check("rst.mem_busy_memreq", 32'(mem_busy_o), 32'd0);
        mem_re_i = 1'b0;

        // Preload RAM while the DUT is held in reset.
        poke(17'h100, 8'h13); poke(17'h101, 8'h05); poke(17'h102, 8'h10); poke(17'h103, 8'h00);
        poke(17'h010, 8'hCD); poke(17'h011, 8'hAB);
        poke(17'h304, 8'h11); poke(17'h305, 8'h22);
        for (int k = 0; k < 12; k++) poke(17'h500 + 17'(k), 8'($urandom));
        for (int k = 0; k < 260; k++) poke(17'h1000 + 17'(k), 8'($urandom));
        rst = 1'b1;

        // Directed vector table.
        for (int v = 0; v < 14; v++) begin
            run_txn($sformatf("vec%0d", v), int'(vecs[v].op), vecs[v].w,
                    vecs[v].addr, vecs[v].wdata, vecs[v].exp);
        end

        // Arbitration: MEM half load and IF fetch raised together.
        $display("txn arb mem_half@010 then if_word@100");
        if_re_i = 1'b1; if_addr_i = 32'h100;
        mem_re_i = 1'b1; mem_addr_i = 32'h10; mem_width_i = 2'b01;
        #1;
        check("arb.if_busy0", 32'(if_busy_o), 32'd1);
        check("arb.mem_busy0", 32'(mem_busy_o), 32'd0);
        @(negedge clk);
        mem_re_i = 1'b0; mem_addr_i = $urandom;
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) @(negedge clk);
            check("arb.mem_done", 32'(mem_done_o), 32'(i == 3));
            check("arb.if_done", 32'(if_done_o), 32'd0);
            check("arb.if_busy", 32'(if_busy_o), 32'(i < 3));
        end
        check("arb.mem_data", mem_data_o, 32'h0000_ABCD);
        last_mem = 32'h0000_ABCD;
        for (int j = 0; j <= 5; j++) begin
            @(negedge clk);
            check("arb.if_done2", 32'(if_done_o), 32'(j == 5));
        end
        check("arb.if_data", if_data_o, 32'h0010_0513);
        last_if = 32'h0010_0513;
        if_re_i = 1'b0;

        // Reset in the middle of a word fetch, fetch request kept high.
        $display("txn reset_abort if_word@100");
        if_re_i = 1'b1; if_addr_i = 32'h100;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rab.ram_a", 32'(ram_a_o), 32'd0);
        check("rab.if_data", if_data_o, 32'd0);
        check("rab.mem_data", mem_data_o, 32'd0);
        check("rab.if_busy", 32'(if_busy_o), 32'd0);
        check("rab.mem_busy", 32'(mem_busy_o), 32'd0);
        last_if = 32'd0; last_mem = 32'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rab.if_done_in_reset", 32'(if_done_o), 32'd0);
        end
        rst = 1'b1;
        for (int j = 0; j <= 5; j++) begin
            @(negedge clk);
            check("rab.if_done", 32'(if_done_o), 32'(j == 5));
        end
        check("rab.if_data_after", if_data_o, 32'h0010_0513);
        last_if = 32'h0010_0513;
        if_re_i = 1'b0;

        // Back-to-back fetches with the request held high.
        if_re_i = 1'b1; if_addr_i = 32'h500;
        for (int w = 0; w < 3; w++) begin
            $display("txn b2b if_word@%h", 32'h500 + 32'(4 * w));
            for (int i = 0; i <= 5; i++) begin
                @(negedge clk);
                check("b2b.if_done", 32'(if_done_o), 32'(i == 5));
            end
            check("b2b.if_data", if_data_o, model_read(17'h500 + 17'(4 * w), 4));
            last_if = model_read(17'h500 + 17'(4 * w), 4);
            if (w < 2) if_addr_i = if_addr_i + 32'd4;
            else if_re_i = 1'b0;
        end

        // Word store stalled by rdy for three edges during byte 1.
        $display("txn stall mem_word_store@600");
        s_wr = '{1, 0, 0, 0, 1, 1, 1, 0};
        s_a  = '{17'h600, 17'h601, 17'h601, 17'h601, 17'h601, 17'h602, 17'h603, 17'h603};
        s_d  = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44, 8'h44};
        mem_we_i = 1'b1; mem_addr_i = 32'h600; mem_width_i = 2'b10; mem_data_i = 32'h4433_2211;
        @(negedge clk);
        mem_we_i = 1'b0; mem_data_i = $urandom;
        for (int i = 0; i <= 7; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1) rdy = 1'b0;
            if (i == 4) rdy = 1'b1;
            #1;
            check("stall.ram_wr", 32'(ram_wr_o), 32'(s_wr[i]));
            check("stall.mem_done", 32'(mem_done_o), 32'(i == 7));
            if (i < 7) begin
                check("stall.ram_a", 32'(ram_a_o), 32'(s_a[i]));
                check("stall.ram_dout", 32'(ram_dout_o), 32'(s_d[i]));
            end
        end
        for (int k = 0; k < 4; k++) check("stall.ram_contents", 32'(ram[17'h600 + 17'(k)]), 32'(8'h11 * (k + 1)));

        // Done pulse held through an rdy stall; no acceptance while stalled.
        $display("txn done_hold mem_byte_store@700");
        mem_we_i = 1'b1; mem_addr_i = 32'h700; mem_width_i = 2'b00; mem_data_i = 32'h0000_005E;
        @(negedge clk);
        mem_we_i = 1'b0;
        check("hold.ram_wr", 32'(ram_wr_o), 32'd1);
        @(negedge clk);
        check("hold.mem_done", 32'(mem_done_o), 32'd1);
        rdy = 1'b0; if_re_i = 1'b1; if_addr_i = 32'h100;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("hold.mem_done_stalled", 32'(mem_done_o), 32'd1);
            check("hold.mem_busy_stalled", 32'(mem_busy_o), 32'd0);
        end
        if_re_i = 1'b0; rdy = 1'b1;
        @(negedge clk);
        check("hold.mem_done_after", 32'(mem_done_o), 32'd0);
        check("hold.no_accept", 32'(if_busy_o), 32'd0);
        check("hold.ram_contents", 32'(ram[17'h700]), 32'h5E);
        check("hold.mem_data", mem_data_o, last_mem);

        // Randomized transactions against the memory model.
        for (int t = 0; t < 150; t++) begin
            int          op;
            int          n;
            logic [1:0]  w;
            logic [31:0] addr;
            logic [31:0] wdata;
            op    = $urandom_range(0, 2);
            w     = 2'($urandom_range(0, 3));
            addr  = ($urandom & 32'hFFFE_0000) | (32'h1000 + 32'($urandom_range(0, 255)));
            wdata = $urandom;
            n     = (op == 0) ? 4 : width_len(w);
            if (op == 2) begin
                run_txn($sformatf("rnd%0d", t), op, w, addr, wdata, 32'd0);
                for (int k = 0; k < n; k++) model_ram[addr[16:0] + 17'(k)] = wdata[8*k +: 8];
            end else begin
                run_txn($sformatf("rnd%0d", t), op, w, addr, wdata, model_read(addr[16:0], n));
            end
        end
        for (int k = 0; k < 260; k++) begin
            check("rnd.ram_window", 32'(ram[17'h1000 + 17'(k)]), 32'(model_ram[17'h1000 + 17'(k)]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
